// File: rtl/zx_scr_loader.sv
// rtl/zx_scr_loader.sv - ZX screen image stream loader into a 13-bit frame buffer
// Optional ZX_SCR_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and ERR flag.
module zx_scr_loader #(
  parameter logic [12:0] BASE_ADDR = 13'h0000,
  parameter int          SCR_BYTES = 6912
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [7:0]  IN_DATA,
  input  logic        IN_VALID,
  output logic        IN_READY,
  output logic        MEM_WE,
  output logic [12:0] MEM_ADDR,
  output logic [7:0]  MEM_DATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

`ifdef ZX_SCR_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_CHECK = 2'd2, S_DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_DONE = 2'd3} state_t;
`endif

  localparam logic [12:0] LP_LAST = 13'(SCR_BYTES - 1);

  state_t      r_state;
  logic [12:0] r_cnt;
  logic        r_ready;
  logic        r_we;
  logic [12:0] r_addr;
  logic [7:0]  r_data;
  logic        r_busy;
  logic        r_done;
  logic        w_accept;
  logic [12:0] w_addr;

  assign w_accept = IN_VALID & r_ready;
  // 13-bit sum wraps naturally at the top of the frame buffer
  assign w_addr   = BASE_ADDR + r_cnt;

`ifdef ZX_SCR_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;
  logic       r_err;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_csum  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (START) begin
            r_state <= S_LOAD;
            r_cnt   <= '0;
            r_csum  <= '0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_we   <= 1'b1;
            r_addr <= w_addr;
            r_data <= IN_DATA;
            r_cnt  <= r_cnt + 13'd1;
            r_csum <= r_csum ^ IN_DATA;
            if (r_cnt == LP_LAST) begin
              r_state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          // checksum byte is compared only, never written to memory
          if (w_accept) begin
            r_err   <= (IN_DATA != r_csum);
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ERR = r_err;
`else
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (START) begin
            r_state <= S_LOAD;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_we   <= 1'b1;
            r_addr <= w_addr;
            r_data <= IN_DATA;
            r_cnt  <= r_cnt + 13'd1;
            // DONE rises together with the final write strobe
            if (r_cnt == LP_LAST) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_ready <= 1'b0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ERR = 1'b0;
`endif

  assign IN_READY = r_ready;
  assign MEM_WE   = r_we;
  assign MEM_ADDR = r_addr;
  assign MEM_DATA = r_data;
  assign BUSY     = r_busy;
  assign DONE     = r_done;

endmodule

// File: tb/tb_zx_scr_loader.sv
// tb/tb_zx_scr_loader.sv - scoreboard bench for zx_scr_loader (default and wrapped base address)
// Honours ZX_SCR_LOADER_CHECKSUM_EN to exercise the checksum build.
module tb_zx_scr_loader;

  localparam int NB = 6912;

  typedef struct {
    logic [12:0] addr;
    logic [7:0]  data;
    int          cyc;
  } exp_t;

  logic        CLK;
  logic        RST;
  logic        START;
  logic [7:0]  IN_DATA;
  logic        IN_VALID;
  logic        IN_READY;
  logic        MEM_WE;
  logic [12:0] MEM_ADDR;
  logic [7:0]  MEM_DATA;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  logic        w_in_ready;
  logic        w_mem_we;
  logic [12:0] w_mem_addr;
  logic [7:0]  w_mem_data;
  logic        w_busy;
  logic        w_done;
  logic        w_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0;
  exp_t e1;

  logic [12:0] p_addr;
  logic [7:0]  p_data;
  logic        prev_rst = 1'b1;
  int          w1_cnt = 0;
  bit          wrap_seen = 0;
  int          wrap_idx = -1;
  logic [7:0]  wrap_data;

  zx_scr_loader dut (
    .CLK(CLK), .RST(RST), .START(START), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  zx_scr_loader #(.BASE_ADDR(13'h1F00)) dut_w (
    .CLK(CLK), .RST(RST), .START(START), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
    .IN_READY(w_in_ready), .MEM_WE(w_mem_we), .MEM_ADDR(w_mem_addr), .MEM_DATA(w_mem_data),
    .BUSY(w_busy), .DONE(w_done), .ERR(w_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    forever begin
      @(posedge CLK);
      cyc++;
    end
  end

  // Write monitor: every strobe must match the next scoreboard entry, one cycle after acceptance
  initial begin
    forever begin
      @(negedge CLK);
      if (MEM_WE === 1'b1) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL wr0_unexpected got addr=%0d data=%0h, required no write", MEM_ADDR, MEM_DATA);
        end else begin
          e0 = q0.pop_front();
          if (MEM_ADDR !== e0.addr || MEM_DATA !== e0.data || cyc != e0.cyc) begin
            errors++;
            $display("FAIL wr0 got addr=%0d data=%0h cyc=%0d, required addr=%0d data=%0h cyc=%0d",
                     MEM_ADDR, MEM_DATA, cyc, e0.addr, e0.data, e0.cyc);
          end
        end
      end else if (!RST && !prev_rst) begin
        checks++;
        if (MEM_ADDR !== p_addr || MEM_DATA !== p_data) begin
          errors++;
          $display("FAIL hold got addr=%0d data=%0h, required addr=%0d data=%0h",
                   MEM_ADDR, MEM_DATA, p_addr, p_data);
        end
      end
      p_addr   = MEM_ADDR;
      p_data   = MEM_DATA;
      prev_rst = RST;

      if (w_mem_we === 1'b1) begin
        checks++;
        if (!wrap_seen && w_mem_addr === 13'd0) begin
          wrap_seen = 1;
          wrap_idx  = w1_cnt;
          wrap_data = w_mem_data;
        end
        w1_cnt++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL wr1_unexpected got addr=%0d data=%0h, required no write", w_mem_addr, w_mem_data);
        end else begin
          e1 = q1.pop_front();
          if (w_mem_addr !== e1.addr || w_mem_data !== e1.data) begin
            errors++;
            $display("FAIL wr1 got addr=%0d data=%0h, required addr=%0d data=%0h",
                     w_mem_addr, w_mem_data, e1.addr, e1.data);
          end
        end
      end
    end
  end

  task automatic start_load();
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    checks++;
    if (BUSY !== 1'b1 || IN_READY !== 1'b1 || DONE !== 1'b0 || MEM_WE !== 1'b0) begin
      errors++;
      $display("FAIL start got busy=%b rdy=%b done=%b we=%b, required 1 1 0 0", BUSY, IN_READY, DONE, MEM_WE);
    end
  endtask

  task automatic stream(input int n, input bit gaps, input int start_at, input bit pat5a);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) begin
        IN_VALID = 1'b0;
        IN_DATA  = 8'hEE;
        @(posedge CLK); #1;
      end
      d = pat5a ? 8'h5A : 8'(i);
      IN_DATA  = d;
      IN_VALID = 1'b1;
      START    = (i == start_at);
      q0.push_back('{addr: 13'(i), data: d, cyc: cyc + 1});
      q1.push_back('{addr: 13'h1F00 + 13'(i), data: d, cyc: cyc + 1});
      @(posedge CLK); #1;
      START = 1'b0;
    end
    IN_VALID = 1'b0;
  endtask

`ifdef ZX_SCR_LOADER_CHECKSUM_EN
  task automatic end_load(input logic [7:0] csum, input logic exp_err);
    @(negedge CLK);
    checks++;
    if (DONE !== 1'b0 || BUSY !== 1'b1 || IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL check_state got done=%b busy=%b rdy=%b, required 0 1 1", DONE, BUSY, IN_READY);
    end
    IN_DATA  = csum;
    IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    @(negedge CLK);
    checks++;
    if (DONE !== 1'b1 || BUSY !== 1'b0 || ERR !== exp_err || MEM_WE !== 1'b0) begin
      errors++;
      $display("FAIL csum_done got done=%b busy=%b err=%b we=%b, required 1 0 %b 0",
               DONE, BUSY, ERR, MEM_WE, exp_err);
    end
  endtask
`else
  task automatic end_load();
    @(negedge CLK);
    checks++;
    if (DONE !== 1'b1 || BUSY !== 1'b0 || MEM_WE !== 1'b1 || IN_READY !== 1'b0 || ERR !== 1'b0) begin
      errors++;
      $display("FAIL done got done=%b busy=%b we=%b rdy=%b err=%b, required 1 0 1 0 0",
               DONE, BUSY, MEM_WE, IN_READY, ERR);
    end
  endtask
`endif

  function automatic logic [7:0] ramp_xor();
    logic [7:0] x = 8'h00;
    for (int i = 0; i < NB; i++) x ^= 8'(i);
    return x;
  endfunction

  task automatic test_reset();
    RST = 1'b1; START = 1'b0; IN_VALID = 1'b0; IN_DATA = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    START = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (IN_READY !== 1'b0 || MEM_WE !== 1'b0 || MEM_ADDR !== 13'd0 || MEM_DATA !== 8'd0 ||
        BUSY !== 1'b0 || DONE !== 1'b0 || ERR !== 1'b0) begin
      errors++;
      $display("FAIL reset got rdy=%b we=%b addr=%0d data=%0h busy=%b done=%b err=%b, required all 0",
               IN_READY, MEM_WE, MEM_ADDR, MEM_DATA, BUSY, DONE, ERR);
    end
    START = 1'b0;
    RST   = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (BUSY !== 1'b0 || IN_READY !== 1'b0) begin
      errors++;
      $display("FAIL idle got busy=%b rdy=%b, required 0 0", BUSY, IN_READY);
    end
  endtask

  task automatic test_full_rate();
    start_load();
    stream(NB, 1'b0, 3000, 1'b0);
`ifdef ZX_SCR_LOADER_CHECKSUM_EN
    end_load(ramp_xor(), 1'b0);
`else
    end_load();
`endif
  endtask

  task automatic test_wrap();
    checks++;
    if (!wrap_seen || wrap_idx != 256 || wrap_data !== 8'h00) begin
      errors++;
      $display("FAIL wrap got seen=%0d idx=%0d data=%0h, required 1 256 00", wrap_seen, wrap_idx, wrap_data);
    end
  endtask

  task automatic test_restart_in_done();
    repeat (5) @(posedge CLK);
    #1;
    checks++;
    if (DONE !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL done_hold got done=%b busy=%b, required 1 0", DONE, BUSY);
    end
    START    = 1'b1;
    IN_VALID = 1'b1;
    IN_DATA  = 8'hAB;
    @(posedge CLK); #1;
    START    = 1'b0;
    IN_VALID = 1'b0;
    checks++;
    if (DONE !== 1'b0 || BUSY !== 1'b1 || IN_READY !== 1'b1 || MEM_WE !== 1'b0 || ERR !== 1'b0) begin
      errors++;
      $display("FAIL restart got done=%b busy=%b rdy=%b we=%b err=%b, required 0 1 1 0 0",
               DONE, BUSY, IN_READY, MEM_WE, ERR);
    end
    stream(NB, 1'b1, -1, 1'b0);
`ifdef ZX_SCR_LOADER_CHECKSUM_EN
    end_load(ramp_xor(), 1'b0);
`else
    end_load();
`endif
  endtask

  task automatic test_reset_abort();
    start_load();
    stream(100, 1'b0, -1, 1'b0);
    RST      = 1'b1;
    START    = 1'b1;
    IN_VALID = 1'b1;
    IN_DATA  = 8'h77;
    @(posedge CLK); #1;
    checks++;
    if (MEM_WE !== 1'b0 || BUSY !== 1'b0 || IN_READY !== 1'b0 || MEM_ADDR !== 13'd0 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL abort got we=%b busy=%b rdy=%b addr=%0d done=%b, required 0 0 0 0 0",
               MEM_WE, BUSY, IN_READY, MEM_ADDR, DONE);
    end
    RST   = 1'b0;
    START = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    checks++;
    if (BUSY !== 1'b0 || IN_READY !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got busy=%b rdy=%b, required 0 0", BUSY, IN_READY);
    end
  endtask

`ifdef ZX_SCR_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    start_load();
    stream(NB, 1'b0, -1, 1'b1);
    end_load(8'h00, 1'b0);
    start_load();
    stream(NB, 1'b0, -1, 1'b1);
    end_load(8'h01, 1'b1);
  endtask
`endif

  task automatic test_drain();
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain got pending=%0d/%0d, required 0/0", q0.size(), q1.size());
    end
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; IN_VALID = 1'b0; IN_DATA = 8'h00;
    test_reset();
    test_full_rate();
    test_wrap();
    test_restart_in_done();
    test_reset_abort();
`ifdef ZX_SCR_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
